// File: rtl/tlb_refill_ctrl_if.sv
// Bank/memory-side bundle of the TLB refill engine.
// The slave modport is the engine's view; master is the TLB bank plus memory arbiter.
interface tlb_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    miss_tlb;
  logic [ADDR_WIDTH-1:0]   addr_tlb;
  logic                    set_tlb;
  logic                    satp_change;

  logic                    busy_rd;
  logic [ADDR_WIDTH-1:0]   addr_rd;
  logic [2*DATA_WIDTH-1:0] data_rd;
  logic                    wen_rd;
  logic                    set_rd;
  logic                    finish_rd;

  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [2*DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  miss_tlb, addr_tlb, set_tlb, satp_change,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output busy_rd, addr_rd, data_rd, wen_rd, set_rd, finish_rd,
    output mem_req, mem_addr
  );

  modport master (
    output miss_tlb, addr_tlb, set_tlb, satp_change,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  busy_rd, addr_rd, data_rd, wen_rd, set_rd, finish_rd,
    input  mem_req, mem_addr
  );
endinterface

// File: rtl/tlb_refill_ctrl.sv
// TLB line refill engine: fetches a line as BANK_NUM/2 double-word beats and streams them to the bank.
// Optional macro TLB_REFILL_FLUSH_EN: satp_change during a refill suppresses the line write-back.
module tlb_refill_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM   = 4
) (
  input logic              clk,
  input logic              rstn,
  tlb_refill_ctrl_if.slave bus
);
  localparam int BEATS      = BANK_NUM / 2;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_BYTES = BANK_NUM * DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 4);
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic                  way;
  logic [BEAT_W-1:0]     beat;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  abort;
  logic                  accept;
  logic                  beat_done;
  logic                  last_beat;

  assign accept    = (state == S_IDLE) && bus.miss_tlb;
  assign beat_done = (state == S_WAIT) && bus.mem_rvalid;
  assign last_beat = (beat == LAST_BEAT);
  assign beat_addr = base + ADDR_WIDTH'(beat) * BEAT_BYTES;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.miss_tlb) state_nxt = S_REQ;
      S_REQ:    if (bus.mem_gnt) state_nxt = S_WAIT;
      S_WAIT:   if (bus.mem_rvalid) begin
                  if (!last_beat)  state_nxt = S_REQ;
                  else if (abort)  state_nxt = S_IDLE;
                  else             state_nxt = S_FINISH;
                end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: rstn is sampled only at the clock edge; state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      base  <= '0;
      way   <= 1'b0;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base <= bus.addr_tlb & LINE_MASK;
        way  <= bus.set_tlb;
        beat <= '0;
      end else if (beat_done && !last_beat) begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

`ifdef TLB_REFILL_FLUSH_EN
  // Sticky until the engine returns to IDLE; the memory sequence still drains so no response is orphaned.
  always_ff @(posedge clk) begin
    if (!rstn)                      abort <= 1'b0;
    else if (state_nxt == S_IDLE)   abort <= 1'b0;
    else if (bus.satp_change)       abort <= 1'b1;
  end
`else
  logic unused_satp_change;
  assign unused_satp_change = bus.satp_change;
  assign abort              = 1'b0;
`endif

  assign bus.busy_rd   = (state != S_IDLE);
  assign bus.set_rd    = (state != S_IDLE) && way;
  assign bus.mem_req   = (state == S_REQ);
  assign bus.mem_addr  = (state == S_REQ) ? beat_addr : '0;
  assign bus.wen_rd    = beat_done && !abort;
  assign bus.data_rd   = beat_done ? bus.mem_rdata : '0;
  assign bus.finish_rd = (state == S_FINISH) && !abort;
  assign bus.addr_rd   = (state == S_WAIT)   ? beat_addr :
                         (state == S_FINISH) ? base      : '0;
endmodule
